freq_meter: RTL and testbench
=============================

// Module: freq_meter
//
// PURPOSE
// Measures the frequency of an external digital signal by counting its rising
// edges over a fixed gate window timed from the system clock. It is the inverse
// of the clock divider chain: the divider makes slow clocks from a known clock,
// and this block reads an unknown clock against a known gate. The default gate
// is 1 s at 50 MHz, so freq is reported directly in Hz. It feeds the calculator
// display/result path.
//
// PARAMETERS
// GATE_CYCLES  50_000_000  clock cycles per gate window (>=2); 1 s at 50 MHz
// CNT_W        32          width of edge counter and freq result
// GATE_W       26          gate counter width; must satisfy 2^GATE_W >= GATE_CYCLES
//
// PORTS
// clock     in   1      system clock, 50 MHz, rising-edge
// reset     in   1      asynchronous, active-low; 0 = reset
// enable    in   1      1 = measure continuously; 0 = abort and idle
// sig_in    in   1      signal under test, asynchronous to clock
// freq      out  CNT_W  rising-edge count of the last completed window
// valid     out  1      one-cycle pulse when freq/overflow update
// overflow  out  1      1 = last completed window saturated the edge counter
// busy      out  1      1 = a window is in progress (state MEASURE)
//
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE. freq=0, valid=0, overflow=0, busy=0.
//   Gate counter, edge counter and sync flops are cleared. Release is synchronous.
// - Input sync: sig_in passes through 2 flops (s1, s2), then a 3rd flop s3.
//   rise = s2 & ~s3. An edge on sig_in registers as rise 2-3 clocks later.
//   Pulses narrower than one clock period are not guaranteed to be seen.
// - FSM has two states: IDLE and MEASURE.
//   IDLE: busy=0, gate_cnt=0, edge_cnt=0. On enable=1, go to MEASURE next cycle.
//   MEASURE: busy=1. Each cycle gate_cnt increments. If rise=1, edge_cnt
//   increments and saturates at 2^CNT_W-1.
//   On the cycle where gate_cnt==GATE_CYCLES-1 (the last cycle of the window):
//     - next freq = edge_cnt + rise (saturated); overflow = saturation occurred
//       during this window;
//     - valid=1 on the next cycle, for exactly one cycle;
//     - gate_cnt and edge_cnt restart at 0 with no dead time, so windows run
//       back-to-back. A rise on the boundary cycle is counted in the closing
//       window only.
//   enable=0 in MEASURE: go to IDLE next cycle. The partial window is discarded:
//   no valid, and freq/overflow keep their last values.
// - Window length is exactly GATE_CYCLES clocks. The first window starts on the
//   cycle after enable is sampled high in IDLE.
// - freq and overflow change only on the cycle valid is asserted. They hold
//   otherwise, including in IDLE.
// - Reset mid-window: everything clears immediately. No valid is issued for the
//   interrupted window.
// - Arithmetic is unsigned. The edge counter never wraps; it saturates.
//
// TESTING (GATE_CYCLES=100, GATE_W=7 unless noted)
// 1. sig_in period 10 clocks (5 high / 5 low), enable=1 -> valid every 100
//    cycles, freq=10, overflow=0 for every window.
// 2. sig_in toggles every clock (clock/2) -> freq=50 each window; valid spacing
//    is exactly 100 cycles.
// 3. CNT_W=4, sig_in period 4 clocks (25 edges/window) -> freq=15, overflow=1.
//    Then switch to period 10 -> next full window gives freq=10, overflow=0.
// 4. enable drops 50 cycles into a window -> no valid, busy=0 one cycle later,
//    freq keeps its old value. Re-enable -> first valid 100 cycles after MEASURE
//    is entered.
// 5. sig_in held at 1 (then at 0) -> freq=0 each window. An edge placed so that
//    rise lands on gate_cnt=99 is counted in that window, not the next one.
// 6. reset=0 pulse mid-window, asynchronous to clock -> all outputs 0
//    immediately. After release with enable=1, the window timing restarts from 0.

Source files
------------

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Measures the frequency of an external signal. Rising edges of
//             sig_in are counted over a fixed gate window of GATE_CYCLES
//             system clocks. Windows run back-to-back while enable is high.
//             With the default 1 s gate at 50 MHz, freq reads directly in Hz.
//  Ports    :
//    clock    in   1      system clock, rising-edge
//    reset    in   1      asynchronous, active-low (0 = reset)
//    enable   in   1      1 = measure continuously, 0 = abort and idle
//    sig_in   in   1      signal under test, asynchronous to clock
//    freq     out  CNT_W  rising-edge count of the last completed window
//    valid    out  1      one-cycle pulse when freq/overflow update
//    overflow out  1      last completed window saturated the edge counter
//    busy     out  1      a window is in progress
//  Revision : 1.0  initial release
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [0:0]        c_idle      = 1'b0;
  localparam logic [0:0]        c_measure   = 1'b1;
  localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] c_gate_one  = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_edge_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_rise;

  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic [CNT_W-1:0]  r_freq;
  logic              r_overflow;
  logic              r_valid;

  logic              w_busy;
  logic              w_counting;
  logic              w_last;
  logic              w_edge_full;
  logic [CNT_W-1:0]  w_edge_nxt;
  logic              w_sat_nxt;

  // Two-flop synchronizer followed by an edge-detect flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:    if (enable)  w_state_nxt = c_measure;
      c_measure: if (!enable) w_state_nxt = c_idle;
      default:   w_state_nxt = c_idle;
    endcase
  end

  // State-derived outputs and window-control strobes.
  always_comb begin
    w_busy     = (r_state == c_measure);
    // Dropping enable discards the window, even on its final cycle.
    w_counting = w_busy & enable;
    w_last     = w_counting & (r_gate_cnt == c_gate_last);
  end

  // Saturating edge count; r_sat remembers that an edge was lost this window.
  assign w_edge_full = &r_edge_cnt;
  assign w_edge_nxt  = (w_rise & ~w_edge_full) ? (r_edge_cnt + c_edge_one) : r_edge_cnt;
  assign w_sat_nxt   = r_sat | (w_rise & w_edge_full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!w_counting) begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else if (w_last) begin
        // Boundary cycle: a rise here belongs to the closing window, and the
        // next window starts immediately with cleared counters.
        r_freq     <= w_edge_nxt;
        r_overflow <= w_sat_nxt;
        r_valid    <= 1'b1;
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_gate_cnt <= r_gate_cnt + c_gate_one;
        r_edge_cnt <= w_edge_nxt;
        r_sat      <= w_sat_nxt;
      end
    end
  end

  assign freq     = r_freq;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Self-checking bench for freq_meter. Two instances (32-bit and
//             4-bit edge counters) share all inputs and are compared every
//             cycle against a window-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_freq_meter;

  localparam int GC = 100;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sig_in;
  logic [31:0] freq_a;
  logic        valid_a, ovf_a, busy_a;
  logic [3:0]  freq_b;
  logic        valid_b, ovf_b, busy_b;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .GATE_W(7)) u_dut_a (
    .clock(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq(freq_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .GATE_W(7)) u_dut_b (
    .clock(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq(freq_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: window position and an unbounded edge count.
  logic        m_busy;
  int          m_pos;
  longint      m_cnt;
  logic [2:0]  m_hist;   // sig_in as sampled at the last three clock edges
  logic        m_valid;
  logic [31:0] m_freq32;
  logic        m_ovf32;
  logic [3:0]  m_freq4;
  logic        m_ovf4;
  int          ph;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_pos = 0; m_cnt = 0; m_hist = '0; m_valid = 1'b0;
    m_freq32 = '0; m_ovf32 = 1'b0; m_freq4 = '0; m_ovf4 = 1'b0;
  endtask

  // One clock edge of the model. An edge of sig_in first sampled high at
  // clock n is counted at clock n+2.
  task automatic model_step(input logic en, input logic s);
    logic rise;
    rise = m_hist[1] & ~m_hist[2];
    m_valid = 1'b0;
    if (!m_busy) begin
      if (en) begin m_busy = 1'b1; m_pos = 0; m_cnt = 0; end
    end else if (!en) begin
      m_busy = 1'b0;
    end else begin
      m_cnt += rise;
      if (m_pos == GC - 1) begin
        m_valid  = 1'b1;
        m_freq32 = (m_cnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[31:0];
        m_ovf32  = (m_cnt > 64'hFFFF_FFFF);
        m_freq4  = (m_cnt > 15) ? 4'hF : m_cnt[3:0];
        m_ovf4   = (m_cnt > 15);
        m_cnt    = 0;
        m_pos    = 0;
      end else begin
        m_pos++;
      end
    end
    m_hist = {m_hist[1:0], s};
  endtask

  task automatic compare_all();
    check("valid32", valid_a, m_valid);
    check("freq32",  freq_a,  m_freq32);
    check("ovf32",   ovf_a,   m_ovf32);
    check("busy32",  busy_a,  m_busy);
    check("valid4",  valid_b, m_valid);
    check("freq4",   freq_b,  m_freq4);
    check("ovf4",    ovf_b,   m_ovf4);
    check("busy4",   busy_b,  m_busy);
  endtask

  task automatic tick(input logic en, input logic s);
    enable = en;
    sig_in = s;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(en, s);
    #1;
    compare_all();
  endtask

  // half > 0: square wave with half-period 'half'; 0: held high; <0: held low
  function automatic logic pat(input int half, input int p);
    if (half == 0) return 1'b1;
    if (half < 0) return 1'b0;
    return ((p / half) % 2) != 0;
  endfunction

  typedef struct {
    int   half;
    int   f32;
    int   f4;
    logic o4;
  } vec_t;

  vec_t tab[7];

  initial begin
    int n;
    logic [31:0] saved;
    logic s;

    tab[0] = '{5,  10, 10, 1'b0};
    tab[1] = '{1,  50, 15, 1'b1};
    tab[2] = '{2,  25, 15, 1'b1};
    tab[3] = '{5,  10, 10, 1'b0};
    tab[4] = '{25,  2,  2, 1'b0};
    tab[5] = '{0,   0,  0, 1'b0};
    tab[6] = '{-1,  0,  0, 1'b0};

    reset = 1'b0; enable = 1'b0; sig_in = 1'b0; ph = 0;
    model_reset();
    #12;
    compare_all();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Periodic patterns: skip the first (mixed) window after each change,
    // then check two clean windows and their spacing.
    for (int i = 0; i < 7; i++) begin
      int nval;
      int t;
      int last_v;
      nval = 0; t = 0; last_v = 0;
      while (nval < 3 && t < 400) begin
        tick(1'b1, pat(tab[i].half, ph));
        ph++; t++;
        if (valid_a) begin
          nval++;
          if (nval >= 2) begin
            check("tab_freq32", freq_a, tab[i].f32);
            check("tab_freq4",  freq_b, tab[i].f4);
            check("tab_ovf4",   ovf_b,  tab[i].o4);
            check("tab_ovf32",  ovf_a,  0);
          end
          if (nval == 3) check("tab_spacing", t - last_v, GC);
          last_v = t;
        end
      end
      check("tab_windows_seen", nval, 3);
    end

    // Boundary: rise on the last cycle of a window counts there only.
    n = 0;
    while (n < 2 && ph < 100000) begin
      tick(1'b1, 1'b0); ph++;
      if (valid_a) n++;
    end
    n = 0;
    while (!(m_busy && m_pos == GC - 3) && n < 200) begin
      tick(1'b1, 1'b0); n++;
    end
    check("bnd_busy", busy_a, 1);
    n = 0;
    while (!valid_a && n < 200) begin
      tick(1'b1, 1'b1); n++;
    end
    check("bnd_closing_freq", freq_a, 1);
    n = 0;
    do begin
      tick(1'b1, 1'b1); n++;
    end while (!valid_a && n < 200);
    check("bnd_next_freq", freq_a, 0);

    // Enable dropped mid-window: window discarded, outputs hold.
    ph = 0;
    n = 0;
    while (!(m_busy && m_pos == 50) && n < 300) begin
      tick(1'b1, pat(5, ph)); ph++; n++;
    end
    check("drop_busy_before", busy_a, 1);
    saved = m_freq32;
    tick(1'b0, pat(5, ph)); ph++;
    check("drop_busy_after", busy_a, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, pat(5, ph)); ph++;
      check("drop_no_valid", valid_a, 0);
      check("drop_freq_hold", freq_a, saved);
    end
    n = 0;
    do begin
      tick(1'b1, pat(5, ph)); ph++; n++;
    end while (!valid_a && n < 300);
    check("reenable_latency", n, GC + 1);

    // Asynchronous reset mid-window.
    n = 0;
    while (!(m_busy && m_pos == 40) && n < 300) begin
      tick(1'b1, pat(5, ph)); ph++; n++;
    end
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick(1'b1, pat(5, ph)); ph++;
    tick(1'b1, pat(5, ph)); ph++;
    #2 reset = 1'b1;
    n = 0;
    do begin
      tick(1'b1, pat(5, ph)); ph++; n++;
    end while (!valid_a && n < 300);
    check("reset_restart_latency", n, GC + 1);

    // Randomized segments with varying toggle density and enable drops.
    s = 1'b0;
    for (int seg = 0; seg < 30; seg++) begin
      int tp;
      int len;
      tp  = $urandom_range(1, 70);
      len = $urandom_range(50, 250);
      for (int i = 0; i < len; i++) begin
        logic en;
        en = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 99) < tp) s = ~s;
        tick(en, s);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
